// File: rtl/datamover_mm2s_reader.sv
// datamover_mm2s_reader: replays the DDR3 capture ring as an AXI-Stream via DataMover MM2S chunk commands
module datamover_mm2s_reader #(
   parameter logic [31:0] BUF_BASE = 32'h0000_0000,
   parameter logic [31:0] BUF_SIZE = 32'h0100_0000,
   parameter int BTT = 4096
) (
   input  logic         axi_aclk,
   input  logic         axi_aresetn,
   input  logic         enable,
   input  logic [31:0]  wr_count,
   output logic [31:0]  rd_count,
   output logic [71:0]  cmd_tdata,
   output logic         cmd_tvalid,
   input  logic         cmd_tready,
   input  logic [7:0]   sts_tdata,
   input  logic         sts_tvalid,
   output logic         sts_tready,
   input  logic [127:0] s_data_tdata,
   input  logic         s_data_tvalid,
   output logic         s_data_tready,
   input  logic         s_data_tlast,
   output logic [127:0] m_data_tdata,
   output logic         m_data_tvalid,
   input  logic         m_data_tready,
   output logic         m_data_tlast,
   output logic         busy,
   output logic         overrun,
   output logic         mm2s_err
);
   typedef enum logic [2:0] {IDLE, CMD, DATA, STS, HALT} state_t;
   localparam logic [31:0] BTT_W = 32'(BTT);
   localparam logic [17:0] LAST_BEAT = 18'(BTT / 16 - 1);
   state_t state, state_d;
   logic [3:0] tag;
   logic [17:0] beat;
   logic [127:0] sk_data;
   logic sk_last, sk_v;
   logic [31:0] avail;
   logic ovf, push, last, frame_bad, sts_ok;
   assign avail = wr_count - rd_count;
   assign ovf = avail > BUF_SIZE;
   assign last = beat == LAST_BEAT;
   assign s_data_tready = state == HALT || (state == DATA && !sk_v);
   assign push = s_data_tvalid && s_data_tready && state == DATA;
   assign frame_bad = s_data_tlast != last;
   assign sts_ok = sts_tdata[7] && sts_tdata[3:0] == tag;
   assign cmd_tvalid = state == CMD;
   assign sts_tready = state == STS || state == HALT;
   assign busy = state != IDLE;
   assign cmd_tdata = {4'h0, tag, BUF_BASE + (rd_count & (BUF_SIZE - 32'd1)),
                       1'b0, 1'b1, 6'h00, 1'b1, BTT_W[22:0]};
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (!ovf && enable && avail >= BTT_W && !mm2s_err) state_d = CMD;
         CMD: if (cmd_tready) state_d = DATA;
         DATA: if (push) state_d = frame_bad ? HALT : (last ? STS : DATA);
         STS: if (sts_tvalid) state_d = sts_ok ? IDLE : HALT;
         default: state_d = HALT;
      endcase
   end
   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state <= IDLE;
         rd_count <= '0;
         tag <= '0;
         beat <= '0;
         overrun <= 1'b0;
         mm2s_err <= 1'b0;
         sk_v <= 1'b0;
         sk_data <= '0;
         sk_last <= 1'b0;
         m_data_tvalid <= 1'b0;
         m_data_tdata <= '0;
         m_data_tlast <= 1'b0;
      end else begin
         state <= state_d;
         if (state == IDLE && ovf) begin
            overrun <= 1'b1;
            rd_count <= wr_count & ~(BTT_W - 32'd1);
         end
         if (state == CMD) beat <= '0;
         if (push) begin
            beat <= beat + 18'd1;
            if (frame_bad) mm2s_err <= 1'b1;
         end
         if (state == STS && sts_tvalid) begin
            if (sts_ok) begin
               rd_count <= rd_count + BTT_W;
               tag <= tag + 4'd1;
            end else mm2s_err <= 1'b1;
         end
         // output register is the head of the 2-entry buffer; the skid only fills when it stalls
         if (!m_data_tvalid || m_data_tready) begin
            m_data_tvalid <= sk_v || push;
            m_data_tdata <= sk_v ? sk_data : s_data_tdata;
            m_data_tlast <= sk_v ? sk_last : last;
            sk_v <= 1'b0;
         end else if (push) begin
            sk_v <= 1'b1;
            sk_data <= s_data_tdata;
            sk_last <= last;
         end
      end
   end
endmodule

// File: tb/tb_datamover_mm2s_reader.sv
// tb_datamover_mm2s_reader: directed scenarios against a cycle-level DataMover/sink model
module tb_datamover_mm2s_reader;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] SIZE = 32'h0000_4000;
   localparam int BTT = 4096;
   localparam int BEATS = BTT / 16;
   logic clk = 0, rstn = 0, enable = 0;
   logic [31:0] wr_count = 0, rd_count;
   logic [71:0] cmd_tdata;
   logic cmd_tvalid, cmd_tready = 0;
   logic [7:0] sts_tdata = 0;
   logic sts_tvalid = 0, sts_tready;
   logic [127:0] s_data_tdata = 0, m_data_tdata;
   logic s_data_tvalid = 0, s_data_tready, s_data_tlast = 0;
   logic m_data_tvalid, m_data_tready = 0, m_data_tlast;
   logic busy, overrun, mm2s_err;
   int checks = 0, failures = 0;
   int cmd_delay, cmd_wait, bad_beat, sts_val, src_beats, seq_in, seq_out, out_beats;
   int ord_err, last_err, cmd_unstable, n_cmd, waited;
   bit tog, phase, src_on, sts_on;
   logic [3:0] cur_tag;
   logic [71:0] cmd_first;
   logic [71:0] cmds [16];

   datamover_mm2s_reader #(.BUF_BASE(BASE), .BUF_SIZE(SIZE), .BTT(BTT)) dut (
      .axi_aclk(clk), .axi_aresetn(rstn), .enable(enable), .wr_count(wr_count),
      .rd_count(rd_count), .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
      .cmd_tready(cmd_tready), .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid),
      .sts_tready(sts_tready), .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid),
      .s_data_tready(s_data_tready), .s_data_tlast(s_data_tlast),
      .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid),
      .m_data_tready(m_data_tready), .m_data_tlast(m_data_tlast),
      .busy(busy), .overrun(overrun), .mm2s_err(mm2s_err));

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   // Inputs are decided at the negedge and are exactly what the next posedge samples.
   task automatic step();
      @(negedge clk);
      phase = tog ? ~phase : 1'b1;
      m_data_tready = phase;
      if (m_data_tvalid && m_data_tready) begin
         if (m_data_tdata !== 128'(seq_out)) ord_err++;
         if (m_data_tlast !== 1'(out_beats % BEATS == BEATS - 1)) last_err++;
         seq_out++;
         out_beats++;
      end
      s_data_tvalid = src_on;
      s_data_tdata = 128'(seq_in);
      s_data_tlast = src_on && (src_beats == BEATS - 1 || src_beats == bad_beat);
      if (src_on && s_data_tready) begin
         seq_in++;
         src_beats++;
         if (s_data_tlast) begin
            src_on = 0;
            sts_on = src_beats == BEATS;
         end
      end
      sts_tvalid = sts_on;
      sts_tdata = sts_val >= 0 ? 8'(sts_val) : {4'h8, cur_tag};
      if (sts_on && sts_tready) sts_on = 0;
      cmd_tready = 0;
      if (cmd_tvalid) begin
         if (cmd_wait == 0) cmd_first = cmd_tdata;
         else if (cmd_tdata !== cmd_first) cmd_unstable++;
         cmd_tready = cmd_wait >= cmd_delay;
         cmd_wait++;
         if (cmd_tready) begin
            if (n_cmd < 16) cmds[n_cmd] = cmd_tdata;
            n_cmd++;
            cur_tag = cmd_tdata[67:64];
            cmd_wait = 0;
            src_on = 1;
            src_beats = 0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_rd(input logic [31:0] tgt, input int budget);
      waited = 0;
      while (rd_count !== tgt && waited < budget) begin
         step();
         waited++;
      end
   endtask

   task automatic do_reset();
      rstn = 0; enable = 0; wr_count = 0;
      cmd_tready = 0; sts_tvalid = 0; s_data_tvalid = 0; s_data_tlast = 0; m_data_tready = 0;
      cmd_delay = 0; cmd_wait = 0; bad_beat = -1; sts_val = -1; src_beats = 0;
      seq_in = 0; seq_out = 0; out_beats = 0; ord_err = 0; last_err = 0;
      cmd_unstable = 0; n_cmd = 0; tog = 0; phase = 0; src_on = 0; sts_on = 0; cur_tag = 0;
      repeat (3) @(negedge clk);
      rstn = 1;
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (rd_count !== 32'd0) begin failures++; $display("FAIL reset_rd_count got=%0h want=0", rd_count); end
      checks++;
      if ({cmd_tvalid, sts_tready, s_data_tready, m_data_tvalid, m_data_tlast, busy, overrun, mm2s_err} !== 8'h00) begin
         failures++;
         $display("FAIL reset_flags got=%b want=00000000",
                  {cmd_tvalid, sts_tready, s_data_tready, m_data_tvalid, m_data_tlast, busy, overrun, mm2s_err});
      end
   endtask

   task automatic test_single_chunk();
      do_reset();
      wr_count = 4096; enable = 1;
      wait_rd(32'd4096, 2000);
      checks++;
      if (waited >= 300) begin failures++; $display("FAIL t1_latency got=%0d want=<300", waited); end
      run(10);
      checks++;
      if (n_cmd !== 1) begin failures++; $display("FAIL t1_ncmd got=%0d want=1", n_cmd); end
      checks++;
      if (cmds[0] !== {4'h0, 4'h0, BASE, 32'h4080_1000}) begin
         failures++; $display("FAIL t1_cmd got=%h want=%h", cmds[0], {4'h0, 4'h0, BASE, 32'h4080_1000});
      end
      checks++;
      if (out_beats !== 256 || ord_err !== 0 || last_err !== 0) begin
         failures++; $display("FAIL t1_beats got=%0d/%0d/%0d want=256/0/0", out_beats, ord_err, last_err);
      end
      checks++;
      if (rd_count !== 32'd4096 || busy !== 1'b0) begin
         failures++; $display("FAIL t1_done got=%0h busy=%b want=1000 busy=0", rd_count, busy);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      enable = 1;
      for (int k = 1; k <= 5; k++) begin
         wr_count = 32'(k * 4096);
         wait_rd(32'(k * 4096), 2000);
      end
      run(10);
      checks++;
      if (n_cmd !== 5) begin failures++; $display("FAIL t2_ncmd got=%0d want=5", n_cmd); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cmds[i][67:64] !== 4'(i)) begin failures++; $display("FAIL t2_tag%0d got=%0d want=%0d", i, cmds[i][67:64], i); end
      end
      checks++;
      if (cmds[1][63:32] !== BASE + 32'h1000) begin failures++; $display("FAIL t2_addr1 got=%h want=%h", cmds[1][63:32], BASE + 32'h1000); end
      checks++;
      if (cmds[4][63:32] !== BASE) begin failures++; $display("FAIL t2_wrap_addr got=%h want=%h", cmds[4][63:32], BASE); end
      checks++;
      if (rd_count !== 32'd20480 || overrun !== 1'b0 || mm2s_err !== 1'b0) begin
         failures++; $display("FAIL t2_done got=%0d ovr=%b err=%b want=20480 ovr=0 err=0", rd_count, overrun, mm2s_err);
      end
      checks++;
      if (out_beats !== 1280 || ord_err !== 0 || last_err !== 0) begin
         failures++; $display("FAIL t2_beats got=%0d/%0d/%0d want=1280/0/0", out_beats, ord_err, last_err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      tog = 1; cmd_delay = 5;
      wr_count = 4096; enable = 1;
      wait_rd(32'd4096, 3000);
      run(10);
      checks++;
      if (out_beats !== 256 || ord_err !== 0 || last_err !== 0) begin
         failures++; $display("FAIL t3_beats got=%0d/%0d/%0d want=256/0/0", out_beats, ord_err, last_err);
      end
      checks++;
      if (n_cmd !== 1 || cmd_unstable !== 0) begin
         failures++; $display("FAIL t3_cmd got=%0d unstable=%0d want=1 unstable=0", n_cmd, cmd_unstable);
      end
      checks++;
      if (rd_count !== 32'd4096) begin failures++; $display("FAIL t3_rd got=%0h want=1000", rd_count); end
   endtask

   task automatic test_overrun();
      do_reset();
      enable = 1; wr_count = 32'h5123;
      run(4);
      checks++;
      if (overrun !== 1'b1 || rd_count !== 32'h5000) begin
         failures++; $display("FAIL t4_resync got=%0h ovr=%b want=5000 ovr=1", rd_count, overrun);
      end
      checks++;
      if (n_cmd !== 0) begin failures++; $display("FAIL t4_nocmd got=%0d want=0", n_cmd); end
      wr_count = 32'h6123;
      wait_rd(32'h6000, 2000);
      checks++;
      if (n_cmd !== 1 || cmds[0][63:32] !== BASE + 32'h1000) begin
         failures++; $display("FAIL t4_addr got=%h n=%0d want=%h n=1", cmds[0][63:32], n_cmd, BASE + 32'h1000);
      end
      checks++;
      if (rd_count !== 32'h6000) begin failures++; $display("FAIL t4_rd got=%0h want=6000", rd_count); end
   endtask

   task automatic test_errors();
      int n;
      do_reset();
      sts_val = 8'h40; wr_count = 4096; enable = 1;
      n = 0;
      while (!mm2s_err && n < 2000) begin step(); n++; end
      wr_count = 8192;
      run(50);
      checks++;
      if (mm2s_err !== 1'b1 || rd_count !== 32'd0) begin
         failures++; $display("FAIL t5_sts got=%b rd=%0h want=1 rd=0", mm2s_err, rd_count);
      end
      checks++;
      if ({busy, s_data_tready, sts_tready, cmd_tvalid} !== 4'b1110 || n_cmd !== 1) begin
         failures++; $display("FAIL t5_halt got=%b n=%0d want=1110 n=1", {busy, s_data_tready, sts_tready, cmd_tvalid}, n_cmd);
      end
      do_reset();
      bad_beat = 100; wr_count = 4096; enable = 1;
      n = 0;
      while (!mm2s_err && n < 2000) begin step(); n++; end
      wr_count = 8192;
      run(50);
      checks++;
      if (mm2s_err !== 1'b1 || rd_count !== 32'd0) begin
         failures++; $display("FAIL t5_tlast got=%b rd=%0h want=1 rd=0", mm2s_err, rd_count);
      end
      checks++;
      if (busy !== 1'b1 || n_cmd !== 1) begin
         failures++; $display("FAIL t5_tlast_halt got=%b n=%0d want=1 n=1", busy, n_cmd);
      end
   endtask

   task automatic test_reset_midchunk();
      int n;
      do_reset();
      tog = 1; wr_count = 4096; enable = 1;
      n = 0;
      while (out_beats < 50 && n < 1000) begin step(); n++; end
      checks++;
      if (out_beats !== 50 || busy !== 1'b1) begin
         failures++; $display("FAIL t6_progress got=%0d busy=%b want=50 busy=1", out_beats, busy);
      end
      rstn = 0;
      @(negedge clk);
      checks++;
      if ({cmd_tvalid, sts_tready, s_data_tready, m_data_tvalid, m_data_tlast, busy, overrun, mm2s_err} !== 8'h00
          || rd_count !== 32'd0) begin
         failures++;
         $display("FAIL t6_reset got=%b rd=%0h want=00000000 rd=0",
                  {cmd_tvalid, sts_tready, s_data_tready, m_data_tvalid, m_data_tlast, busy, overrun, mm2s_err}, rd_count);
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single_chunk();
      test_wrap();
      test_backpressure();
      test_overrun();
      test_errors();
      test_reset_midchunk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
